// File: rtl/booth_mem_pkg.sv
// booth_mem_pkg: shared widths and fetch state encoding for the operand memory read side
package booth_mem_pkg;
  localparam int DATA_W = 9;
  localparam int ADDR_W = 4;
  localparam int CNT_W = ADDR_W + 1;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_DONE} fetch_state_e;
endpackage

// File: rtl/booth_operand_fetch.sv
// booth_operand_fetch: walks an address range, pairs bank-1/bank-2 words and hands them to the Booth multiplier.
// OPFETCH_ZERO_SKIP_EN: when defined, pairs with a zero operand are dropped and counted in Skip_Cnt.
module booth_operand_fetch
  import booth_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] Base_Addr,
  input  logic [ADDR_WIDTH:0]   Count,
  output logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] Data1_I,
  input  logic [DATA_WIDTH-1:0] Data2_I,
  output logic [DATA_WIDTH-1:0] Op_A,
  output logic [DATA_WIDTH-1:0] Op_B,
  output logic                  Op_Valid,
  input  logic                  Op_Ready,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_WIDTH:0]   Skip_Cnt
);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
  localparam logic [ADDR_WIDTH:0] ONE_C = 1;
  fetch_state_e state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0] rem_q, skip_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
  logic zero;
`ifdef OPFETCH_ZERO_SKIP_EN
  assign zero = (Data1_I == '0) || (Data2_I == '0);
`else
  assign zero = 1'b0;
`endif
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      addr_q <= '0;
      rem_q <= '0;
      skip_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (Start) begin
          skip_q <= '0;
          rem_q <= Count;
          addr_q <= (Count != '0) ? Base_Addr : addr_q;
          state_q <= (Count != '0) ? ST_FETCH : ST_DONE;
        end
        ST_FETCH: if (zero) begin
          // dropped pair still consumes one slot of the run
          skip_q <= skip_q + ONE_C;
          rem_q <= rem_q - ONE_C;
          addr_q <= (rem_q == ONE_C) ? addr_q : addr_q + ONE_A;
          state_q <= (rem_q == ONE_C) ? ST_DONE : ST_FETCH;
        end else begin
          op_a_q <= Data1_I;
          op_b_q <= Data2_I;
          state_q <= ST_HOLD;
        end
        ST_HOLD: if (Op_Ready) begin
          rem_q <= rem_q - ONE_C;
          addr_q <= (rem_q == ONE_C) ? addr_q : addr_q + ONE_A;
          state_q <= (rem_q == ONE_C) ? ST_DONE : ST_FETCH;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign Addr = addr_q;
  assign Op_A = op_a_q;
  assign Op_B = op_b_q;
  assign Op_Valid = state_q == ST_HOLD;
  assign Busy = (state_q == ST_FETCH) || (state_q == ST_HOLD);
  assign Done = state_q == ST_DONE;
  assign Skip_Cnt = skip_q;
endmodule

// File: tb/tb_booth_operand_fetch.sv
// tb_booth_operand_fetch: randomized runs against an in-bench memory and expected-pair queue model.
module tb_booth_operand_fetch;
  localparam int DW = 9;
  localparam int AW = 4;
`ifdef OPFETCH_ZERO_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  logic Clk = 1'b0;
  logic Rst, Start, Op_Valid, Op_Ready, Busy, Done;
  logic [AW-1:0] Base_Addr, Addr;
  logic [AW:0] Count, Skip_Cnt;
  logic [DW-1:0] Data1_I, Data2_I, Op_A, Op_B;
  logic [DW-1:0] ram1 [16];
  logic [DW-1:0] ram2 [16];
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {int addr; int a; int b;} pair_t;

  booth_operand_fetch dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Base_Addr(Base_Addr), .Count(Count),
    .Addr(Addr), .Data1_I(Data1_I), .Data2_I(Data2_I), .Op_A(Op_A), .Op_B(Op_B),
    .Op_Valid(Op_Valid), .Op_Ready(Op_Ready), .Busy(Busy), .Done(Done), .Skip_Cnt(Skip_Cnt)
  );

  assign Data1_I = ram1[Addr];
  assign Data2_I = ram2[Addr];
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for 5 cycles of first hold plus stray Start
  task automatic run(input int base, input int cnt, input int mode);
    pair_t exp_q[$];
    int nskip, npairs, got, done_cyc, cyc, pa, pb, pad, ad;
    bit stall, busy_seen, valid_seen;
    nskip = 0; got = 0; done_cyc = -1; stall = 0; busy_seen = 0; valid_seen = 0;
    pa = 0; pb = 0; pad = 0;
    for (int i = 0; i < cnt; i++) begin
      ad = (base + i) % 16;
      if (SKIP_EN && (ram1[ad] == 0 || ram2[ad] == 0)) nskip++;
      else exp_q.push_back('{ad, int'(ram1[ad]), int'(ram2[ad])});
    end
    npairs = exp_q.size();
    @(negedge Clk);
    Start = 1; Base_Addr = AW'(base); Count = (AW+1)'(cnt); Op_Ready = 1;
    @(posedge Clk); #1;
    Start = 0; Base_Addr = AW'($urandom); Count = (AW+1)'($urandom);
    for (cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      Op_Ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(cyc >= 2 && cyc < 7);
      Start = mode == 2 && cyc == 3;
      @(negedge Clk);
      if (Busy) busy_seen = 1;
      if (Op_Valid) valid_seen = 1;
      if (stall) begin
        chk("hold_valid", Op_Valid, 1);
        chk("hold_a", Op_A, pa);
        chk("hold_b", Op_B, pb);
        chk("hold_addr", Addr, pad);
      end
      if (Done) done_cyc = cyc;
      else if (Op_Valid && Op_Ready) begin
        got++;
        if (exp_q.size() > 0) begin
          pair_t e;
          e = exp_q.pop_front();
          chk("pair_addr", Addr, e.addr);
          chk("pair_a", Op_A, e.a);
          chk("pair_b", Op_B, e.b);
        end
      end
      stall = Op_Valid && !Op_Ready;
      pa = Op_A; pb = Op_B; pad = Addr;
      @(posedge Clk); #1;
    end
    Start = 0;
    chk("done_seen", int'(done_cyc > 0), 1);
    chk("pairs", got, npairs);
    chk("skip_cnt", Skip_Cnt, nskip);
    if (mode == 0) chk("done_cycle", done_cyc, 2 * npairs + nskip + 1);
    if (cnt == 0) begin
      chk("cnt0_busy", busy_seen, 0);
      chk("cnt0_valid", valid_seen, 0);
    end
    @(negedge Clk);
    chk("done_pulse", Done, 0);
    chk("idle_busy", Busy, 0);
  endtask

  task automatic reset_mid_hold();
    bit done_seen;
    done_seen = 0;
    @(negedge Clk);
    Start = 1; Base_Addr = 2; Count = 4; Op_Ready = 1;
    @(posedge Clk); #1;
    Start = 0;
    repeat (3) begin @(posedge Clk); #1; end
    Op_Ready = 0;
    @(negedge Clk);
    chk("rst_pre_valid", Op_Valid, 1);
    chk("rst_pre_addr", Addr, 3);
    Rst = 1;
    @(posedge Clk); #1;
    Rst = 0;
    @(negedge Clk);
    chk("rst_valid", Op_Valid, 0);
    chk("rst_addr", Addr, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_opa", Op_A, 0);
    repeat (4) begin
      if (Done) done_seen = 1;
      @(negedge Clk);
    end
    chk("rst_no_done", done_seen, 0);
  endtask

  initial begin
    Rst = 1; Start = 0; Op_Ready = 0; Base_Addr = 0; Count = 0;
    for (int i = 0; i < 16; i++) begin
      ram1[i] = DW'(i + 1);
      ram2[i] = DW'(2 * i + 3);
    end
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_addr", Addr, 0);
    chk("reset_opa", Op_A, 0);
    chk("reset_opb", Op_B, 0);
    chk("reset_valid", Op_Valid, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_skip", Skip_Cnt, 0);
    Rst = 0;
    reset_mid_hold();
    run(0, 3, 0);
    run(14, 4, 0);
    run(5, 2, 2);
    run(3, 0, 0);
    ram1[1] = 0;
    run(0, 3, 0);
    ram1[1] = 2;
    run(7, 16, 0);
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 16; i++) begin
        ram1[i] = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
        ram2[i] = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      end
      run($urandom_range(0, 15), $urandom_range(0, 16), $urandom_range(0, 1));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
